dm_access_ctrl: RTL and testbench
=================================

Name: dm_access_ctrl

Overview:
- MEM-stage controller placed directly upstream of the word-only data memory (DM).
- Converts pipeline load/store requests (lw/lh/lhu/lb/lbu/sw/sh/sb) into whole-word DM accesses.
- Implements sub-word stores as a two-cycle read-modify-write (RMW) and stalls the pipeline for that one extra cycle.
- Returns sign/zero-extended load data through a one-cycle registered MEM/WB output.

Parameters:
- ADDR_W, 32, byte address width presented to DM.
- DATA_W, 32, word width; only 32 is supported.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  a memory instruction is present in MEM this cycle
- req_op  input  3  0=LW 1=LH 2=LHU 3=LB 4=LBU 5=SW 6=SH 7=SB
- req_addr  input  32  effective byte address
- req_wdata  input  32  store data; sub-word stores use the low bits
- req_pc  input  32  PC of the instruction, for the DM write trace
- stall_out  output  1  combinational; upstream must hold its request this cycle
- load_valid  output  1  registered; load_data is valid
- load_data  output  32  registered, extended load result
- misalign_err  output  1  registered one-cycle pulse on a misaligned access
- dm_a  output  32  DM address
- dm_wd  output  32  DM write word
- dm_we  output  1  DM write enable
- dm_re  output  1  DM read enable
- dm_pc  output  32  PC forwarded to DM for write tracing
- dm_rd  input  32  DM combinational read data

Behaviour:
- Reset (synchronous): state=IDLE; load_valid=0, load_data=0, misalign_err=0, merge_word=0, held_addr=0, held_pc=0.
  - dm_we is gated by ~reset in every state, so a reset during MERGE suppresses the pending write.
- Alignment rule: word ops need addr[1:0]=00; half ops need addr[0]=0; byte ops are always aligned.
  - Misaligned request: no DM access (dm_re=dm_we=0), no stall.
  - Next cycle: misalign_err=1, load_valid=0.
- Byte order is little-endian. Byte lane k=addr[1:0] occupies bits [8k+7:8k]; half lane h=addr[1] occupies bits [16h+15:16h].
- Idle outputs: dm_a=0, dm_wd=0, dm_re=0, dm_we=0, dm_pc=0, stall_out=0.
- FSM states: IDLE, MERGE.
- IDLE with a valid, aligned request:
  - LW/LH/LHU/LB/LBU:
    - Same cycle: dm_re=1, dm_a={addr[31:2],2'b00}.
    - Next edge: load_data=extend(lane of dm_rd), load_valid=1.
    - Latency 1, no stall.
  - SW:
    - Same cycle: dm_we=1, dm_a=addr, dm_wd=wdata, dm_pc=pc.
    - No stall; load_valid=0 next cycle.
  - SH/SB:
    - Same cycle: dm_re=1, dm_a=word address, stall_out=1.
    - Next edge: merge_word = dm_rd with the lane replaced by wdata[15:0] or wdata[7:0]; held_addr and held_pc latched; state→MERGE.
- MERGE (one cycle):
  - dm_we=1, dm_a=held_addr word-aligned, dm_wd=merge_word, dm_pc=held_pc, stall_out=0.
  - Upstream still presents the same SH/SB request; it retires this cycle and its inputs are ignored.
  - state→IDLE; load_valid=0.
- load_valid and misalign_err are 0 on any cycle following no request, a store, or an RMW cycle.
- Extension: LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
- Back-to-back cases:
  - SB then LW to the same word: the LW is presented after MERGE and reads the merged value.
  - LW immediately after SW: DM updates at the edge, so the LW in the next cycle reads the new data.

Decomposition:
- Shared package mem_pkg:
  - op encodings OP_LW..OP_SB
  - state enum {IDLE, MERGE}
  - helper constants BYTE_W=8 and HALF_W=16
- Sub-module load_ext: combinational lane select plus sign/zero extension (inputs word, op, addr[1:0]). It is reused by the merge logic for lane position only.

Test Plan:
- Reset, then LW at 0x10 with dm_rd=0xDEADBEEF → next cycle load_valid=1, load_data=0xDEADBEEF; dm_re=1 and dm_a=0x10 in the request cycle.
- LB at 0x13 with word 0x80FF1234 → load_data=0xFFFFFF80; LBU at the same address → 0x00000080; LH at 0x12 → 0xFFFF80FF.
- SB at 0x21 with wdata=0xAB over a DM word of 0x11223344:
  - cycle 1: stall_out=1, dm_re=1;
  - cycle 2: dm_we=1, dm_a=0x20, dm_wd=0x1122AB44, dm_pc equals the SB's PC;
  - a following LW at 0x20 returns 0x1122AB44.
- SH at 0x22 with wdata=0x5566 over 0x11223344 → dm_wd=0x55663344. SW at 0x24 → single-cycle dm_we with no stall.
- Misaligned LW at 0x31 and SH at 0x33 → dm_we=dm_re=0, misalign_err=1 for exactly one cycle each, load_valid=0.
- Assert reset while in MERGE → dm_we stays 0 (DM unchanged); all registered outputs are 0 next cycle; state is IDLE.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data-memory access path.
package mem_pkg;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    typedef enum logic {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } state_t;

    // Word ops need a 4-byte boundary, half ops a 2-byte boundary, bytes always fit.
    function automatic logic is_aligned(input logic [2:0] op, input logic [1:0] lo);
        case (op)
            OP_LW, OP_SW:         is_aligned = (lo == 2'b00);
            OP_LH, OP_LHU, OP_SH: is_aligned = ~lo[0];
            default:              is_aligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/load_ext.sv
// Lane select and sign/zero extension for loads; the lane mask it also
// produces tells the store-merge path which bits a sub-word store replaces.
module load_ext
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [2:0]  op,
    input  logic [1:0]  lane,
    output logic [31:0] data,
    output logic [31:0] lane_mask
);

    logic [31:0] byte_sh;
    logic [31:0] half_sh;
    logic [BYTE_W-1:0] byte_v;
    logic [HALF_W-1:0] half_v;

    // Shift the addressed lane down to bit 0 (little-endian lanes).
    always_comb begin
        byte_sh = word >> {lane, 3'b000};
        half_sh = word >> {lane[1], 4'b0000};
        byte_v  = byte_sh[BYTE_W-1:0];
        half_v  = half_sh[HALF_W-1:0];
    end

    // Extend the selected lane and build the in-word mask for that lane.
    always_comb begin
        data      = word;
        lane_mask = 32'hFFFF_FFFF;
        case (op)
            OP_LH: begin
                data      = {{HALF_W{half_v[HALF_W-1]}}, half_v};
                lane_mask = 32'h0000_FFFF << {lane[1], 4'b0000};
            end
            OP_LHU, OP_SH: begin
                data      = {{HALF_W{1'b0}}, half_v};
                lane_mask = 32'h0000_FFFF << {lane[1], 4'b0000};
            end
            OP_LB: begin
                data      = {{(32-BYTE_W){byte_v[BYTE_W-1]}}, byte_v};
                lane_mask = 32'h0000_00FF << {lane, 3'b000};
            end
            OP_LBU, OP_SB: begin
                data      = {{(32-BYTE_W){1'b0}}, byte_v};
                lane_mask = 32'h0000_00FF << {lane, 3'b000};
            end
            default: begin
                data      = word;
                lane_mask = 32'hFFFF_FFFF;
            end
        endcase
    end

endmodule

// File: rtl/dm_access_ctrl.sv
// MEM-stage controller in front of a word-only data memory: loads are
// one-cycle reads with registered extension, SW is a direct write, and
// SH/SB become a read cycle (with stall) followed by a merged-word write.
module dm_access_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [31:0]       req_pc,
    output logic              stall_out,
    output logic              load_valid,
    output logic [DATA_W-1:0] load_data,
    output logic              misalign_err,
    output logic [ADDR_W-1:0] dm_a,
    output logic [DATA_W-1:0] dm_wd,
    output logic              dm_we,
    output logic              dm_re,
    output logic [31:0]       dm_pc,
    input  logic [DATA_W-1:0] dm_rd
);

    state_t            state, state_nxt;
    logic [DATA_W-1:0] merge_word, merge_nxt;
    logic [ADDR_W-1:0] held_addr;
    logic [31:0]       held_pc;
    logic [DATA_W-1:0] ext_data, lane_mask, st_rep;
    logic [ADDR_W-1:0] word_addr;
    logic              aligned, dm_we_raw;
    logic              go_load, go_rmw, go_mis;

    assign aligned   = is_aligned(req_op, req_addr[1:0]);
    assign word_addr = {req_addr[ADDR_W-1:2], 2'b00};

    load_ext u_load_ext (
        .word      (dm_rd),
        .op        (req_op),
        .lane      (req_addr[1:0]),
        .data      (ext_data),
        .lane_mask (lane_mask)
    );

    // Replicate the store datum across the word; the lane mask picks where it lands.
    always_comb begin
        st_rep    = (req_op == OP_SB) ? {4{req_wdata[BYTE_W-1:0]}} : {2{req_wdata[HALF_W-1:0]}};
        merge_nxt = (dm_rd & ~lane_mask) | (st_rep & lane_mask);
    end

    // Next state and DM-side outputs; MERGE ignores the held upstream request.
    always_comb begin
        state_nxt = state;
        dm_a      = '0;
        dm_wd     = '0;
        dm_re     = 1'b0;
        dm_we_raw = 1'b0;
        dm_pc     = '0;
        stall_out = 1'b0;
        go_load   = 1'b0;
        go_rmw    = 1'b0;
        go_mis    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (!aligned) begin
                        go_mis = 1'b1;
                    end else begin
                        case (req_op)
                            OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: begin
                                dm_re   = 1'b1;
                                dm_a    = word_addr;
                                go_load = 1'b1;
                            end
                            OP_SW: begin
                                dm_we_raw = 1'b1;
                                dm_a      = req_addr;
                                dm_wd     = req_wdata;
                                dm_pc     = req_pc;
                            end
                            default: begin
                                dm_re     = 1'b1;
                                dm_a      = word_addr;
                                stall_out = 1'b1;
                                go_rmw    = 1'b1;
                                state_nxt = MERGE;
                            end
                        endcase
                    end
                end
            end
            MERGE: begin
                dm_we_raw = 1'b1;
                dm_a      = {held_addr[ADDR_W-1:2], 2'b00};
                dm_wd     = merge_word;
                dm_pc     = held_pc;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Reset must be able to cancel a pending merge write in the same cycle.
    assign dm_we = dm_we_raw & ~reset;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // MEM/WB result registers and the RMW holding registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_valid   <= 1'b0;
            load_data    <= '0;
            misalign_err <= 1'b0;
            merge_word   <= '0;
            held_addr    <= '0;
            held_pc      <= '0;
        end else begin
            load_valid   <= go_load;
            misalign_err <= go_mis;
            if (go_load) load_data <= ext_data;
            if (go_rmw) begin
                merge_word <= merge_nxt;
                held_addr  <= req_addr;
                held_pc    <= req_pc;
            end
        end
    end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl with a small behavioural word memory.
module tb_dm_access_ctrl;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_addr, req_wdata, req_pc;
    logic        stall_out, load_valid, misalign_err, dm_we, dm_re;
    logic [31:0] load_data, dm_a, dm_wd, dm_pc, dm_rd;

    always #5 clk = ~clk;

    dm_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_pc(req_pc),
        .stall_out(stall_out), .load_valid(load_valid), .load_data(load_data),
        .misalign_err(misalign_err),
        .dm_a(dm_a), .dm_wd(dm_wd), .dm_we(dm_we), .dm_re(dm_re), .dm_pc(dm_pc),
        .dm_rd(dm_rd)
    );

    // Word memory: combinational read, write at the edge; preload port for setup.
    logic [31:0] mem [0:63];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = '0;
    logic [31:0] pl_data = '0;
    always @(posedge clk) begin
        if (dm_we) mem[dm_a[7:2]] <= dm_wd;
        if (pl_en) mem[pl_idx] <= pl_data;
    end
    assign dm_rd = mem[dm_a[7:2]];

    typedef struct {
        string       name;
        logic        v;
        logic [2:0]  op;
        logic [31:0] a, wd, pc;
        logic        stall, re, we;
        logic [31:0] ea, ewd, epc;
        logic        mis;
        logic        ld;
        logic [31:0] ldx;
    } vec_t;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] sb_q [$];
    logic        exp_mis;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic v, input logic [2:0] op,
                                input logic [31:0] a, input logic [31:0] wd, input logic [31:0] pc,
                                input logic st, input logic re, input logic we,
                                input logic [31:0] ea, input logic [31:0] ewd, input logic [31:0] epc,
                                input logic mis, input logic ld, input logic [31:0] ldx);
        vec_t r;
        r.name = n; r.v = v; r.op = op; r.a = a; r.wd = wd; r.pc = pc;
        r.stall = st; r.re = re; r.we = we; r.ea = ea; r.ewd = ewd; r.epc = epc;
        r.mis = mis; r.ld = ld; r.ldx = ldx;
        return r;
    endfunction

    function automatic vec_t ld_v(input string n, input logic [2:0] op,
                                  input logic [31:0] a, input logic [31:0] x);
        return mk(n, 1'b1, op, a, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0,
                  {a[31:2], 2'b00}, 32'h0, 32'h0, 1'b0, 1'b1, x);
    endfunction

    function automatic vec_t idle_v(input string n);
        return mk(n, 1'b0, OP_LW, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0,
                  32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    endfunction

    task automatic preload(input logic [5:0] idx, input logic [31:0] d);
        @(negedge clk);
        req_valid = 1'b0;
        pl_en = 1'b1; pl_idx = idx; pl_data = d;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    // One cycle: drive at negedge, check combinational DM side, then the registered side.
    task automatic apply(input vec_t v);
        @(negedge clk);
        reset = 1'b0;
        req_valid = v.v; req_op = v.op; req_addr = v.a; req_wdata = v.wd; req_pc = v.pc;
        #1;
        chk({v.name, " stall"}, stall_out, v.stall);
        chk({v.name, " dm_re"}, dm_re, v.re);
        chk({v.name, " dm_we"}, dm_we, v.we);
        if (v.re || v.we) chk({v.name, " dm_a"}, dm_a, v.ea);
        if (v.we) begin
            chk({v.name, " dm_wd"}, dm_wd, v.ewd);
            chk({v.name, " dm_pc"}, dm_pc, v.epc);
        end
        if (!v.v) chk({v.name, " idle dm_a"}, dm_a, 32'h0);
        if (v.v && v.ld) sb_q.push_back(v.ldx);
        exp_mis = v.mis;
        @(posedge clk);
        #1;
        chk({v.name, " misalign"}, misalign_err, exp_mis);
        if (sb_q.size() > 0) begin
            chk({v.name, " load_valid"}, load_valid, 1'b1);
            chk({v.name, " load_data"}, load_data, sb_q.pop_front());
        end else begin
            chk({v.name, " load_valid"}, load_valid, 1'b0);
        end
    endtask

    vec_t tbl [9];

    initial begin
        tbl[0] = ld_v("lb13",  OP_LB,  32'h13, 32'hFFFF_FF80);
        tbl[1] = ld_v("lbu13", OP_LBU, 32'h13, 32'h0000_0080);
        tbl[2] = ld_v("lh12",  OP_LH,  32'h12, 32'hFFFF_80FF);
        tbl[3] = ld_v("lhu12", OP_LHU, 32'h12, 32'h0000_80FF);
        tbl[4] = ld_v("lb10",  OP_LB,  32'h10, 32'h0000_0034);
        tbl[5] = ld_v("lb11",  OP_LB,  32'h11, 32'h0000_0012);
        tbl[6] = ld_v("lbu12", OP_LBU, 32'h12, 32'h0000_00FF);
        tbl[7] = ld_v("lh10",  OP_LH,  32'h10, 32'h0000_1234);
        tbl[8] = idle_v("idle");

        reset = 1'b1;
        req_valid = 1'b0; req_op = OP_LW; req_addr = '0; req_wdata = '0; req_pc = '0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h10;
        @(posedge clk);
        #1;
        chk("reset load_valid", load_valid, 1'b0);
        chk("reset load_data", load_data, 32'h0);
        chk("reset misalign", misalign_err, 1'b0);
        chk("reset dm_we", dm_we, 1'b0);

        // Plain word load.
        preload(6'd4, 32'hDEAD_BEEF);
        apply(ld_v("lw10", OP_LW, 32'h10, 32'hDEAD_BEEF));

        // Sub-word load extension table.
        preload(6'd4, 32'h80FF_1234);
        foreach (tbl[i]) apply(tbl[i]);

        // SB read-modify-write, then a load of the merged word.
        preload(6'd8, 32'h1122_3344);
        apply(mk("sb21 rd", 1'b1, OP_SB, 32'h21, 32'h7777_77AB, 32'h100,
                 1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0));
        apply(mk("sb21 wr", 1'b1, OP_SB, 32'h21, 32'h7777_77AB, 32'h100,
                 1'b0, 1'b0, 1'b1, 32'h20, 32'h1122_AB44, 32'h100, 1'b0, 1'b0, 32'h0));
        apply(ld_v("lw20 after sb", OP_LW, 32'h20, 32'h1122_AB44));

        // SH merge, SW single cycle, LW right after SW.
        preload(6'd8, 32'h1122_3344);
        apply(mk("sh22 rd", 1'b1, OP_SH, 32'h22, 32'h0000_5566, 32'h104,
                 1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0));
        apply(mk("sh22 wr", 1'b1, OP_SH, 32'h22, 32'h0000_5566, 32'h104,
                 1'b0, 1'b0, 1'b1, 32'h20, 32'h5566_3344, 32'h104, 1'b0, 1'b0, 32'h0));
        apply(mk("sw24", 1'b1, OP_SW, 32'h24, 32'hCAFE_F00D, 32'h200,
                 1'b0, 1'b0, 1'b1, 32'h24, 32'hCAFE_F00D, 32'h200, 1'b0, 1'b0, 32'h0));
        apply(ld_v("lw24 after sw", OP_LW, 32'h24, 32'hCAFE_F00D));

        // Misaligned accesses: one-cycle error pulse, no DM access.
        apply(mk("lw31 mis", 1'b1, OP_LW, 32'h31, 32'h0, 32'h0,
                 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0));
        apply(idle_v("after lw31"));
        apply(mk("sh33 mis", 1'b1, OP_SH, 32'h33, 32'h1234, 32'h0,
                 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0));
        apply(idle_v("after sh33"));

        // Reset during MERGE cancels the write and clears the registered outputs.
        preload(6'd16, 32'h1122_3344);
        apply(mk("sb40 rd", 1'b1, OP_SB, 32'h40, 32'h99, 32'h300,
                 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0));
        @(negedge clk);
        reset = 1'b1;
        #1 chk("merge reset dm_we", dm_we, 1'b0);
        @(posedge clk);
        #1;
        chk("merge reset mem", mem[16], 32'h1122_3344);
        chk("merge reset load_valid", load_valid, 1'b0);
        chk("merge reset load_data", load_data, 32'h0);
        chk("merge reset misalign", misalign_err, 1'b0);
        apply(ld_v("lw40 after reset", OP_LW, 32'h40, 32'h1122_3344));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
